// File: rtl/keypad_emulator.sv
// keypad_emulator
//   Responder side of a 4x4 matrix-keypad scan interface. It stands in for a
//   physical keypad between a scanner's column strobes and its row inputs. A
//   key press is requested over a valid/ready handshake. While the contact is
//   closed, the latched key's row line follows the latched column strobe with
//   no register stage. Contact bounce can optionally be injected on press and
//   on release.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous reset, active-high
//   key_valid  in   1  press request
//   key_ready  out  1  request accepted when high (IDLE and not in reset)
//   key_code   in   4  key to press: row = key_code[3:2], col = key_code[1:0]
//   key_bounce in   1  1 = inject bounce on press and release
//   col_in     in   4  column strobes from scanner, active-low
//   row_out    out  4  row sense lines, active-low, idle 4'hF
//   busy       out  1  high whenever a press sequence is in progress
//   pressed    out  1  registered contact state (1 = closed)
module keypad_emulator #(
  parameter int HOLD_CYCLES    = 2000,
  parameter int BOUNCE_CYCLES  = 64,
  parameter int BOUNCE_TOGGLES = 4,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] key_code,
  input  logic       key_bounce,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       busy,
  output logic       pressed
);

  localparam int HALVES = 2 * BOUNCE_TOGGLES;
  localparam int HP_W   = (HALVES > 2) ? $clog2(HALVES) : 1;

  // Counters run down from period-1 to 0, so every phase lasts exactly period cycles.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BNC_LOAD  = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [HP_W-1:0]  HP_LAST   = HP_W'(HALVES - 1);
  localparam logic [HP_W-1:0]  HP_ZERO   = HP_W'(0);
  localparam logic [HP_W-1:0]  HP_ONE    = HP_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    BNC_PRESS = 3'd1,
    HOLD      = 3'd2,
    BNC_REL   = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t           state_r,   state_s;
  logic [CNT_W-1:0] cnt_r,     cnt_s;
  logic [HP_W-1:0]  half_r,    half_s;
  logic             pressed_r, pressed_s;
  logic [3:0]       code_r,    code_s;
  logic             bounce_r,  bounce_s;

  // State, counters, contact and latched request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      half_r    <= HP_ZERO;
      pressed_r <= 1'b0;
      code_r    <= 4'h0;
      bounce_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      half_r    <= half_s;
      pressed_r <= pressed_s;
      code_r    <= code_s;
      bounce_r  <= bounce_s;
    end
  end

  // Next-state logic; the contact value for the coming phase is set on the edge that enters it.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    half_s    = half_r;
    pressed_s = pressed_r;
    code_s    = code_r;
    bounce_s  = bounce_r;
    case (state_r)
      IDLE: begin
        pressed_s = 1'b0;
        if (key_valid) begin
          code_s    = key_code;
          bounce_s  = key_bounce;
          // Both the bounce pattern and the plain hold start with the contact closed.
          pressed_s = 1'b1;
          half_s    = HP_ZERO;
          if (key_bounce) begin
            state_s = BNC_PRESS;
            cnt_s   = BNC_LOAD;
          end else begin
            state_s = HOLD;
            cnt_s   = HOLD_LOAD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BNC_PRESS: begin
        if (cnt_r == CNT_ZERO) begin
          if (half_r == HP_LAST) begin
            state_s   = HOLD;
            cnt_s     = HOLD_LOAD;
            pressed_s = 1'b1;
          end else begin
            half_s    = half_r + HP_ONE;
            cnt_s     = BNC_LOAD;
            pressed_s = ~pressed_r;
          end
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt_r == CNT_ZERO) begin
          // Release bounce starts open, so the contact opens on this edge either way.
          pressed_s = 1'b0;
          half_s    = HP_ZERO;
          if (bounce_r) begin
            state_s = BNC_REL;
            cnt_s   = BNC_LOAD;
          end else begin
            state_s = GAP;
            cnt_s   = HOLD_LOAD;
          end
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      BNC_REL: begin
        if (cnt_r == CNT_ZERO) begin
          if (half_r == HP_LAST) begin
            state_s   = GAP;
            cnt_s     = HOLD_LOAD;
            pressed_s = 1'b0;
          end else begin
            half_s    = half_r + HP_ONE;
            cnt_s     = BNC_LOAD;
            pressed_s = ~pressed_r;
          end
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      GAP: begin
        pressed_s = 1'b0;
        if (cnt_r == CNT_ZERO) begin
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s   = IDLE;
        cnt_s     = CNT_ZERO;
        half_s    = HP_ZERO;
        pressed_s = 1'b0;
      end
    endcase
  end

  // Row sense: zero-latency path from the column strobes, gated by the registered contact.
  always_comb begin
    row_out = 4'hF;
    if (pressed_r && (col_in[code_r[1:0]] == 1'b0)) begin
      row_out[code_r[3:2]] = 1'b0;
    end else begin
      row_out = 4'hF;
    end
  end

  assign pressed   = pressed_r;
  assign busy      = (state_r != IDLE);
  assign key_ready = (state_r == IDLE) && !rst;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator
//   Randomized bench for keypad_emulator. The stimulus process drives inputs
//   shortly after each falling edge and, whenever a press is accepted,
//   pushes the complete expected contact waveform for that press (one entry
//   per cycle, built from the phase lengths) into a queue. A monitor on the
//   falling edge pops one entry per cycle and compares pressed, row_out, busy
//   and key_ready; an empty queue means the keypad must be idle.
module tb_keypad_emulator;

  localparam int HOLD = 10;
  localparam int BNC  = 3;
  localparam int TOG  = 2;

  logic       clk;
  logic       rst;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] key_code;
  logic       key_bounce;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic       busy;
  logic       pressed;

  keypad_emulator #(
    .HOLD_CYCLES   (HOLD),
    .BOUNCE_CYCLES (BNC),
    .BOUNCE_TOGGLES(TOG),
    .CNT_W         (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_code  (key_code),
    .key_bounce(key_bounce),
    .col_in    (col_in),
    .row_out   (row_out),
    .busy      (busy),
    .pressed   (pressed)
  );

  typedef struct packed {
    logic       pr;
    logic [3:0] key;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Model bookkeeping: cycles of busy still ahead, and what the last edge will do.
  int   left     = 0;
  int   new_len  = 0;
  logic acc_pend = 1'b0;
  logic rst_pend = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected contact waveform of one press, one entry per cycle after the accept edge.
  task automatic push_press(input logic [3:0] k, input logic b);
    exp_t e;
    e.key   = k;
    new_len = 0;
    if (b) begin
      for (int i = 0; i < 2 * TOG; i++)
        for (int j = 0; j < BNC; j++) begin
          e.pr = (i % 2 == 0);
          q.push_back(e);
          new_len++;
        end
    end
    for (int j = 0; j < HOLD; j++) begin
      e.pr = 1'b1;
      q.push_back(e);
      new_len++;
    end
    if (b) begin
      for (int i = 0; i < 2 * TOG; i++)
        for (int j = 0; j < BNC; j++) begin
          e.pr = (i % 2 == 1);
          q.push_back(e);
          new_len++;
        end
    end
    for (int j = 0; j < HOLD; j++) begin
      e.pr = 1'b0;
      q.push_back(e);
      new_len++;
    end
  endtask

  // Move to the next drive point and account for what the previous edge did.
  task automatic advance();
    @(negedge clk);
    #1;
    if (rst_pend) left = 0;
    else if (acc_pend) left = new_len;
    else if (left > 0) left--;
  endtask

  // Called after inputs are set: predict what the coming edge does.
  task automatic commit();
    if (rst) begin
      q.delete();
      rst_pend = 1'b1;
      acc_pend = 1'b0;
    end else begin
      rst_pend = 1'b0;
      acc_pend = (left == 0) && key_valid;
      if (acc_pend) push_press(key_code, key_bounce);
    end
  endtask

  // Monitor: one expected entry per cycle while busy, idle expectations otherwise.
  always @(negedge clk) begin
    exp_t       e;
    logic       ep, eb, ek;
    logic [3:0] er;
    if (q.size() > 0) begin
      e  = q.pop_front();
      ep = e.pr;
      eb = 1'b1;
      ek = 1'b0;
    end else begin
      e  = '0;
      ep = 1'b0;
      eb = 1'b0;
      ek = !rst;
    end
    er = 4'hF;
    if (ep && (col_in[e.key[1:0]] == 1'b0)) er[e.key[3:2]] = 1'b0;
    check("pressed",   {3'b000, pressed},   {3'b000, ep});
    check("row_out",   row_out,             er);
    check("busy",      {3'b000, busy},      {3'b000, eb});
    check("key_ready", {3'b000, key_ready}, {3'b000, ek});
  end

  initial begin
    logic [3:0] one;
    one        = 4'b0001;
    rst        = 1'b1;
    key_valid  = 1'b1;
    key_code   = 4'h6;
    key_bounce = 1'b0;
    col_in     = 4'hF;
    commit();
    // Reset held for three edges with a request pending: nothing may be accepted.
    repeat (2) begin
      advance();
      commit();
    end
    advance();
    rst       = 1'b0;
    key_valid = 1'b0;
    commit();

    for (int n = 0; n < 3000; n++) begin
      advance();
      rst = ($urandom_range(0, 199) == 0);
      if (!rst) key_valid = ($urandom_range(0, 3) != 0);
      key_code   = 4'($urandom);
      key_bounce = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       col_in = 4'($urandom);
        1:       col_in = ~(one << $urandom_range(0, 3));
        2:       col_in = 4'h0;
        default: col_in = 4'hF;
      endcase
      commit();
    end

    advance();
    rst       = 1'b0;
    key_valid = 1'b0;
    commit();
    for (int n = 0; n < 200 && left != 0; n++) begin
      advance();
      commit();
    end
    repeat (3) begin
      advance();
      commit();
    end
    check("drained", 4'(q.size()), 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
